alu_seq_unit: RTL

- Parametrised, handshaked successor to the board-level 4-bit combinational ALU.
- Operand width is generic and operations are widened to shifts and a multi-cycle shift-add multiply.
- Each result is registered together with carry/overflow/zero flags.
- An accumulator mode chains results without re-entering operand A.
- Sits between switch/button input logic and the LED/seven-segment display logic of the NPC board top.

---
 rtl/alu_seq_pkg.sv | 33 +++
 rtl/alu_seq_comb.sv | 63 ++++++
 rtl/alu_seq_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and the flag bundle.
// Optional divider is enabled by defining ALU_SEQ_UNIT_DIV_EN.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_NOT = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SLT = 4'd6,
        OP_EQ  = 4'd7,
        OP_MUL = 4'd8,
        OP_SHL = 4'd9,
        OP_SRA = 4'd10,
        OP_DIV = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic err;
    } flags_t;

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle combinational datapath. MUL/DIV are iterated by the parent, so here they
// only count as legal (no err) and produce a don't-care zero result.
// Op 11 is legal only when ALU_SEQ_UNIT_DIV_EN is defined.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [SHW-1:0]   shamt;

    assign add_sum = {1'b0, a} + {1'b0, b};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
    assign shamt   = b[SHW-1:0];

    // Decode op and compute result plus flags
    always_comb begin
        result = '0;
        flags  = '0;
        case (op)
            OP_ADD: begin
                result         = add_sum[WIDTH-1:0];
                flags.carry    = add_sum[WIDTH];
                flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                                 (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result         = sub_sum[WIDTH-1:0];
                flags.carry    = sub_sum[WIDTH];
                flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                                 (sub_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT: result = ~a;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_EQ:  result = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_MUL: begin
                // iterated in the parent
            end
            OP_SHL: result = a << shamt;
            OP_SRA: result = $signed(a) >>> shamt;
`ifdef ALU_SEQ_UNIT_DIV_EN
            OP_DIV: begin
                // iterated in the parent
            end
`endif
            default: flags.err = 1'b1;
        endcase
        flags.zero = (result == '0);
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked sequential ALU: IDLE/EXEC/DONE FSM, shift-add multiplier, accumulator.
// Defining ALU_SEQ_UNIT_DIV_EN adds an unsigned restoring divider on op 11.
module alu_seq_unit
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             acc_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             err,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    flags_t             flags_q, flags_d;
    // Multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0]   operand_q, operand_d;
    // MUL: {partial high, multiplier}; DIV: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   comb_result;
    flags_t             comb_flags;
    logic               start_multi;
    logic               is_div;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] step_next;
    logic               step_ovf;

    assign opa = acc_sel ? acc_q : a;

    alu_seq_comb #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_comb (
        .op     (op),
        .a      (opa),
        .b      (b),
        .result (comb_result),
        .flags  (comb_flags)
    );

    // One shift-add step: add multiplicand if the multiplier LSB is set, then shift right
    always_comb begin
        mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} +
                   (work_q[0] ? {1'b0, operand_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, work_q[WIDTH-1:1]};
    end

`ifdef ALU_SEQ_UNIT_DIV_EN
    logic               div_q, div_d;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH:0]     div_rem;
    logic [2*WIDTH-1:0] div_next;

    // One restoring-divide step: shift in next dividend bit, subtract if it fits
    always_comb begin
        div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, operand_q});
        div_rem   = div_ge ? (div_shift - {1'b0, operand_q}) : div_shift;
        div_next  = {div_rem[WIDTH-1:0], work_q[WIDTH-2:0], div_ge};
        is_div    = (op == OP_DIV);
        step_next = div_q ? div_next : mul_next;
        // Divide by zero already yields all-ones quotient; flag it
        step_ovf  = div_q ? (operand_q == '0) : (|mul_next[2*WIDTH-1:WIDTH]);
    end
`else
    // Select the iterated step result (multiply only)
    always_comb begin
        is_div    = 1'b0;
        step_next = mul_next;
        step_ovf  = |mul_next[2*WIDTH-1:WIDTH];
    end
`endif

    assign start_multi = (op == OP_MUL) || is_div;

    // FSM next-state, iterator and accumulator update
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        result_d  = result_q;
        flags_d   = flags_q;
        operand_d = operand_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
`ifdef ALU_SEQ_UNIT_DIV_EN
        div_d     = div_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (start_multi) begin
                        state_d   = EXEC;
                        cnt_d     = '0;
                        operand_d = is_div ? b : opa;
                        work_d    = {{WIDTH{1'b0}}, (is_div ? opa : b)};
`ifdef ALU_SEQ_UNIT_DIV_EN
                        div_d     = is_div;
`endif
                    end else begin
                        state_d  = DONE;
                        result_d = comb_result;
                        flags_d  = comb_flags;
                        acc_d    = comb_result;
                    end
                end
            end
            EXEC: begin
                work_d = step_next;
                cnt_d  = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d          = DONE;
                    result_d         = step_next[WIDTH-1:0];
                    flags_d          = '0;
                    flags_d.overflow = step_ovf;
                    flags_d.zero     = (step_next[WIDTH-1:0] == '0);
                    acc_d            = step_next[WIDTH-1:0];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; reset discards any in-flight iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            operand_q <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
`ifdef ALU_SEQ_UNIT_DIV_EN
            div_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            operand_q <= operand_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
`ifdef ALU_SEQ_UNIT_DIV_EN
            div_q     <= div_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == EXEC);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry     = flags_q.carry;
    assign overflow  = flags_q.overflow;
    assign zero      = flags_q.zero;
    assign err       = flags_q.err;

endmodule
